alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit_pkg.sv | 72 +++++++
 rtl/alu_exec_unit_fwd_select.sv | 55 +++++
 rtl/alu_exec_unit.sv | 132 +++++++++++++
 tb/tb_alu_exec_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared constants for the EX-stage ALU and its forwarding selector:
//   - R-type funct field codes
//   - ALUCtrl instruction-class codes (aliases share a code with their base)
//   - ALUOp operation codes driven on the ALUOp port
//   - forwarding mux select values used by ForA / ForB
// Also holds the R-type funct decode helper used by alu_exec_unit.
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

  // R-type funct field
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MUL  = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // ALUCtrl instruction classes
  localparam logic [2:0] CTRL_R    = 3'b000;
  localparam logic [2:0] CTRL_ADDI = 3'b001;
  localparam logic [2:0] CTRL_LUI  = 3'b010;
  localparam logic [2:0] CTRL_ORI  = 3'b011;
  localparam logic [2:0] CTRL_BEQ  = 3'b100;
  // Classes that reuse another class's datapath behaviour
  localparam logic [2:0] CTRL_LW   = CTRL_ADDI;
  localparam logic [2:0] CTRL_SW   = CTRL_ADDI;
  localparam logic [2:0] CTRL_J    = CTRL_ADDI;
  localparam logic [2:0] CTRL_JAL  = CTRL_ADDI;
  localparam logic [2:0] CTRL_BNE  = CTRL_BEQ;

  // ALUOp encoding
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_MFHI = 4'd8;
  localparam logic [3:0] OP_MFLO = 4'd9;

  // Forwarding mux selects
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

  // R-type funct -> ALUOp. Jr only needs a harmless pass-through add;
  // unrecognised funct codes also fall back to add.
  function automatic logic [3:0] decodeFunct(input logic [5:0] funct);
    logic [3:0] op;
    op = OP_ADD;
    case (funct)
      FUNCT_ADD, FUNCT_JR: op = OP_ADD;
      FUNCT_SUB:           op = OP_SUB;
      FUNCT_SLL:           op = OP_SLL;
      FUNCT_MUL:           op = OP_MUL;
      FUNCT_SLT:           op = OP_SLT;
      FUNCT_DIV:           op = OP_DIV;
      FUNCT_MFHI:          op = OP_MFHI;
      FUNCT_MFLO:          op = OP_MFLO;
      default:             op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_unit_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Purely combinational EX-stage forwarding selector.
// Ports:
//   IDEX_RegRs, IDEX_RegRt   in  5  source registers of the instruction in EX
//   EXMEM_RegRd, MEMWB_RegRd in  5  destinations of the two older instructions
//   EXMEM_RegWrite           in  1  EX/MEM instruction writes a register
//   EXMEM_MemWrite           in  1  EX/MEM instruction is a store
//   MEMWB_RegWrite           in  1  MEM/WB instruction writes a register
//   MEMWB_MemToReg           in  1  MEM/WB instruction is a load
//   ForA, ForB               out 2  operand mux select (FWD_REG/MEMWB/EXMEM)
//   ForC                     out 1  store data taken from the MEM/WB load
// ---------------------------------------------------------------------------
module fwd_select
  import alu_exec_unit_pkg::*;
(
  input  logic [4:0] IDEX_RegRs,
  input  logic [4:0] IDEX_RegRt,
  input  logic [4:0] EXMEM_RegRd,
  input  logic [4:0] MEMWB_RegRd,
  input  logic       EXMEM_RegWrite,
  input  logic       EXMEM_MemWrite,
  input  logic       MEMWB_RegWrite,
  input  logic       MEMWB_MemToReg,
  output logic [1:0] ForA,
  output logic [1:0] ForB,
  output logic       ForC
);

  logic [1:0][4:0] srcReg;
  logic [1:0][1:0] fwdSel;

  assign srcReg = {IDEX_RegRt, IDEX_RegRs};

  // Same rule for both operands. EX/MEM is tested first because it holds the
  // younger (more recent) value; $zero is never a forwarding source.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSrc
      assign fwdSel[gi] =
        (EXMEM_RegWrite && (EXMEM_RegRd != 5'd0) && (EXMEM_RegRd == srcReg[gi])) ? FWD_EXMEM :
        (MEMWB_RegWrite && (MEMWB_RegRd != 5'd0) && (MEMWB_RegRd == srcReg[gi])) ? FWD_MEMWB :
                                                                                    FWD_REG;
    end
  endgenerate

  assign ForA = fwdSel[0];
  assign ForB = fwdSel[1];

  // Load immediately followed by a store of the loaded register: the store
  // data comes from the value the load is writing back.
  assign ForC = EXMEM_MemWrite && MEMWB_RegWrite && MEMWB_MemToReg &&
                (MEMWB_RegRd != 5'd0) && (MEMWB_RegRd == EXMEM_RegRd);

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// EX-stage execution unit: ALU control decode, 32-bit ALU datapath, HI/LO
// divide result registers and the operand forwarding selector.
// Ports:
//   Clock          in  1   rising-edge clock (only HI/LO are clocked)
//   Reset          in  1   asynchronous active-high, clears HI/LO
//   Funct          in  6   R-type funct field
//   ALUCtrl        in  3   decoded instruction class
//   A, B           in  32  operands
//   Shamt          in  5   shift amount for SLL
//   IDEX_*/EXMEM_*/MEMWB_*  pipeline register fields for forwarding
//   ALUOp          out 4   decoded operation
//   ALUOut         out 32  combinational result
//   ForA, ForB     out 2   operand forwarding selects
//   ForC           out 1   load-to-store data forward
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [5:0]  Funct,
  input  logic [2:0]  ALUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  input  logic [4:0]  IDEX_RegRs,
  input  logic [4:0]  IDEX_RegRt,
  input  logic [4:0]  EXMEM_RegRd,
  input  logic [4:0]  MEMWB_RegRd,
  input  logic        EXMEM_RegWrite,
  input  logic        EXMEM_MemWrite,
  input  logic        MEMWB_RegWrite,
  input  logic        MEMWB_MemToReg,
  output logic [3:0]  ALUOp,
  output logic [31:0] ALUOut,
  output logic [1:0]  ForA,
  output logic [1:0]  ForB,
  output logic        ForC
);

  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] mulLow;
  logic [31:0] divisor;
  logic [31:0] divQuot;
  logic [31:0] divRem;
  logic        divLoad;
  logic        isBranch;
  logic        isImmAdd;

  // ---------------- ALU control decode ----------------
  assign isBranch = (ALUCtrl == CTRL_BEQ) || (ALUCtrl == CTRL_BNE);
  assign isImmAdd = (ALUCtrl == CTRL_ADDI) || (ALUCtrl == CTRL_LW) ||
                    (ALUCtrl == CTRL_SW)   || (ALUCtrl == CTRL_J)  ||
                    (ALUCtrl == CTRL_JAL);

  always_comb begin
    ALUOp = OP_ADD;
    if (ALUCtrl == CTRL_R) begin
      ALUOp = decodeFunct(Funct);
    end else if (ALUCtrl == CTRL_LUI) begin
      ALUOp = OP_LUI;
    end else if (ALUCtrl == CTRL_ORI) begin
      ALUOp = OP_OR;
    end else if (isBranch) begin
      ALUOp = OP_SUB;   // branches compare by subtraction
    end else if (isImmAdd) begin
      ALUOp = OP_ADD;   // address/immediate add
    end else begin
      ALUOp = OP_ADD;   // unassigned class codes 101-111
    end
  end

  // ---------------- Datapath ----------------
  // The low half of a two's-complement product is the same for signed and
  // unsigned operands, so a 32-bit signed multiply gives the wanted bits.
  assign mulLow = 32'($signed(A) * $signed(B));

  // Substitute a divisor of 1 when B is zero so the divider never sees a
  // zero operand; the result is discarded in that case anyway.
  assign divisor = (B == 32'd0) ? 32'd1 : B;
  assign divQuot = 32'($signed(A) / $signed(divisor));
  assign divRem  = 32'($signed(A) % $signed(divisor));

  always_comb begin
    ALUOut = 32'd0;
    case (ALUOp)
      OP_ADD:  ALUOut = A + B;
      OP_SUB:  ALUOut = A - B;
      OP_SLL:  ALUOut = B << Shamt;
      OP_MUL:  ALUOut = mulLow;
      OP_SLT:  ALUOut = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      OP_LUI:  ALUOut = {B[15:0], 16'h0000};
      OP_OR:   ALUOut = A | B;
      OP_DIV:  ALUOut = 32'd0;   // result lands in HI/LO on the next edge
      OP_MFHI: ALUOut = hiReg;
      OP_MFLO: ALUOut = loReg;
      default: ALUOut = 32'd0;
    endcase
  end

  // ---------------- HI/LO ----------------
  assign divLoad = (ALUOp == OP_DIV) && (B != 32'd0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hiReg <= 32'd0;
      loReg <= 32'd0;
    end else if (divLoad) begin
      hiReg <= divRem;
      loReg <= divQuot;
    end
  end

  // ---------------- Forwarding ----------------
  fwd_select uFwd (
    .IDEX_RegRs     (IDEX_RegRs),
    .IDEX_RegRt     (IDEX_RegRt),
    .EXMEM_RegRd    (EXMEM_RegRd),
    .MEMWB_RegRd    (MEMWB_RegRd),
    .EXMEM_RegWrite (EXMEM_RegWrite),
    .EXMEM_MemWrite (EXMEM_MemWrite),
    .MEMWB_RegWrite (MEMWB_RegWrite),
    .MEMWB_MemToReg (MEMWB_MemToReg),
    .ForA           (ForA),
    .ForB           (ForB),
    .ForC           (ForC)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        Clock;
  logic        Reset;
  logic [5:0]  Funct;
  logic [2:0]  ALUCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic [4:0]  IDEX_RegRs;
  logic [4:0]  IDEX_RegRt;
  logic [4:0]  EXMEM_RegRd;
  logic [4:0]  MEMWB_RegRd;
  logic        EXMEM_RegWrite;
  logic        EXMEM_MemWrite;
  logic        MEMWB_RegWrite;
  logic        MEMWB_MemToReg;
  logic [3:0]  ALUOp;
  logic [31:0] ALUOut;
  logic [1:0]  ForA;
  logic [1:0]  ForB;
  logic        ForC;

  int vectorCount = 0;
  int missCount   = 0;

  alu_exec_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Funct          (Funct),
    .ALUCtrl        (ALUCtrl),
    .A              (A),
    .B              (B),
    .Shamt          (Shamt),
    .IDEX_RegRs     (IDEX_RegRs),
    .IDEX_RegRt     (IDEX_RegRt),
    .EXMEM_RegRd    (EXMEM_RegRd),
    .MEMWB_RegRd    (MEMWB_RegRd),
    .EXMEM_RegWrite (EXMEM_RegWrite),
    .EXMEM_MemWrite (EXMEM_MemWrite),
    .MEMWB_RegWrite (MEMWB_RegWrite),
    .MEMWB_MemToReg (MEMWB_MemToReg),
    .ALUOp          (ALUOp),
    .ALUOut         (ALUOut),
    .ForA           (ForA),
    .ForB           (ForB),
    .ForC           (ForC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("  ok %s: 0x%08h", tag, got);
    end
  endtask

  // Apply an ALU vector and let it settle between clock edges
  task automatic applyAlu(input logic [2:0] ctrl, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b);
    ALUCtrl = ctrl;
    Funct   = fn;
    A       = a;
    B       = b;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issue DIV across one rising edge, then switch to MFHI
  task automatic doDiv(input logic [31:0] a, input logic [31:0] b);
    applyAlu(CTRL_R, FUNCT_DIV, a, b);
    checkVal("div_aluout_zero", ALUOut, 32'd0);
    tick();
    applyAlu(CTRL_R, FUNCT_MFHI, a, b);
  endtask

  task automatic setFwd(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] exRd, input logic [4:0] wbRd,
                        input logic exWr, input logic exMw,
                        input logic wbWr, input logic wbM2r);
    IDEX_RegRs     = rs;
    IDEX_RegRt     = rt;
    EXMEM_RegRd    = exRd;
    MEMWB_RegRd    = wbRd;
    EXMEM_RegWrite = exWr;
    EXMEM_MemWrite = exMw;
    MEMWB_RegWrite = wbWr;
    MEMWB_MemToReg = wbM2r;
    #1;
  endtask

  logic [2:0] addAliases [4];

  initial begin
    Reset = 1'b1;
    Shamt = 5'd0;
    applyAlu(CTRL_R, FUNCT_MFHI, 32'd0, 32'd0);
    setFwd(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    checkVal("rst_aluop_mfhi", 32'(ALUOp), 32'd8);
    checkVal("rst_mfhi", ALUOut, 32'd0);
    applyAlu(CTRL_R, FUNCT_MFLO, 32'd0, 32'd0);
    checkVal("rst_mflo", ALUOut, 32'd0);
    tick();
    tick();
    Reset = 1'b0;

    // R-type, A=5 B=3
    applyAlu(CTRL_R, FUNCT_ADD, 32'd5, 32'd3);
    checkVal("r_add_op", 32'(ALUOp), 32'd0);
    checkVal("r_add", ALUOut, 32'd8);
    applyAlu(CTRL_R, FUNCT_SUB, 32'd5, 32'd3);
    checkVal("r_sub_op", 32'(ALUOp), 32'd1);
    checkVal("r_sub", ALUOut, 32'd2);
    applyAlu(CTRL_R, FUNCT_SLT, 32'd5, 32'd3);
    checkVal("r_slt_op", 32'(ALUOp), 32'd4);
    checkVal("r_slt_5_3", ALUOut, 32'd0);
    applyAlu(CTRL_R, FUNCT_SLT, 32'hFFFF_FFFF, 32'd1);
    checkVal("r_slt_m1_1", ALUOut, 32'd1);
    applyAlu(CTRL_R, FUNCT_MUL, 32'hFFFF_FFFF, 32'd1);
    checkVal("r_mul_op", 32'(ALUOp), 32'd3);
    checkVal("r_mul_m1_1", ALUOut, 32'hFFFF_FFFF);
    applyAlu(CTRL_R, FUNCT_MUL, 32'hFFFF_FFFF, 32'd0);
    checkVal("r_mul_m1_0", ALUOut, 32'd0);
    applyAlu(CTRL_R, FUNCT_MUL, 32'hFFFF_FFFD, 32'd7);
    checkVal("r_mul_m3_7", ALUOut, 32'hFFFF_FFEB);
    Shamt = 5'd4;
    applyAlu(CTRL_R, FUNCT_SLL, 32'd5, 32'd3);
    checkVal("r_sll_op", 32'(ALUOp), 32'd2);
    checkVal("r_sll", ALUOut, 32'd48);
    Shamt = 5'd0;
    applyAlu(CTRL_R, FUNCT_JR, 32'd5, 32'd3);
    checkVal("r_jr", ALUOut, 32'd8);
    applyAlu(CTRL_R, 6'h3F, 32'd5, 32'd3);
    checkVal("r_unknown_op", 32'(ALUOp), 32'd0);
    checkVal("r_unknown", ALUOut, 32'd8);

    // Immediate classes
    applyAlu(CTRL_LUI, 6'h00, 32'd0, 32'h1234_ABCD);
    checkVal("lui_op", 32'(ALUOp), 32'd5);
    checkVal("lui", ALUOut, 32'hABCD_0000);
    applyAlu(CTRL_ORI, 6'h00, 32'h0000_00F0, 32'h0000_000F);
    checkVal("ori_op", 32'(ALUOp), 32'd6);
    checkVal("ori", ALUOut, 32'h0000_00FF);
    applyAlu(CTRL_BEQ, 6'h00, 32'd7, 32'd7);
    checkVal("beq_op", 32'(ALUOp), 32'd1);
    checkVal("beq", ALUOut, 32'd0);
    applyAlu(CTRL_BNE, 6'h00, 32'd7, 32'd7);
    checkVal("bne", ALUOut, 32'd0);
    addAliases = '{CTRL_LW, CTRL_SW, CTRL_J, CTRL_JAL};
    foreach (addAliases[i]) begin
      applyAlu(addAliases[i], FUNCT_SUB, 32'd4, 32'd8);
      checkVal($sformatf("addalias_%0d", i), ALUOut, 32'd12);
    end
    for (int c = 5; c < 8; c++) begin
      applyAlu(3'(c), FUNCT_SUB, 32'd4, 32'd8);
      checkVal($sformatf("ctrl_%0d_op", c), 32'(ALUOp), 32'd0);
      checkVal($sformatf("ctrl_%0d", c), ALUOut, 32'd12);
    end

    // DIV / HI / LO
    doDiv(32'd6, 32'd3);
    checkVal("div_6_3_hi", ALUOut, 32'd0);
    doDiv(32'd1, 32'd3);
    checkVal("div_1_3_hi", ALUOut, 32'd1);
    doDiv(32'd11, 32'd3);
    checkVal("div_11_3_hi", ALUOut, 32'd2);
    applyAlu(CTRL_R, FUNCT_MFLO, 32'd0, 32'd0);
    checkVal("div_11_3_lo", ALUOut, 32'd3);
    // Divide by zero leaves HI/LO alone
    doDiv(32'd5, 32'd0);
    checkVal("div_by0_hi", ALUOut, 32'd2);
    applyAlu(CTRL_R, FUNCT_MFLO, 32'd0, 32'd0);
    checkVal("div_by0_lo", ALUOut, 32'd3);
    // Non-DIV ops across an edge do not disturb HI/LO
    applyAlu(CTRL_R, FUNCT_ADD, 32'd9, 32'd9);
    tick();
    applyAlu(CTRL_R, FUNCT_MFHI, 32'd0, 32'd0);
    checkVal("nondiv_hold_hi", ALUOut, 32'd2);
    // Negative dividend: truncate toward zero, remainder takes sign of A
    doDiv(32'hFFFF_FFF9, 32'd2);
    checkVal("div_m7_2_hi", ALUOut, 32'hFFFF_FFFF);
    applyAlu(CTRL_R, FUNCT_MFLO, 32'd0, 32'd0);
    checkVal("div_m7_2_lo", ALUOut, 32'hFFFF_FFFD);

    // Reset held across DIV
    Reset = 1'b1;
    applyAlu(CTRL_R, FUNCT_MFHI, 32'd0, 32'd0);
    checkVal("async_rst_hi", ALUOut, 32'd0);
    applyAlu(CTRL_R, FUNCT_DIV, 32'd10, 32'd3);
    tick();
    tick();
    applyAlu(CTRL_R, FUNCT_MFHI, 32'd10, 32'd3);
    checkVal("rst_div_hi", ALUOut, 32'd0);
    applyAlu(CTRL_R, FUNCT_MFLO, 32'd10, 32'd3);
    checkVal("rst_div_lo", ALUOut, 32'd0);
    applyAlu(CTRL_R, FUNCT_MFHI, 32'd10, 32'd3);
    Reset = 1'b0;
    tick();
    tick();
    checkVal("post_rst_hi", ALUOut, 32'd0);
    doDiv(32'd10, 32'd3);
    checkVal("post_rst_div_hi", ALUOut, 32'd1);

    // Forwarding: rs, rt, exRd, wbRd, exWr, exMw, wbWr, wbM2r
    setFwd(5'd5, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("fora_exmem", 32'(ForA), 32'd2);
    setFwd(5'd5, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("fora_memwb", 32'(ForA), 32'd1);
    setFwd(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("fora_r0", 32'(ForA), 32'd0);
    setFwd(5'd5, 5'd0, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("fora_memwb_only_match", 32'(ForA), 32'd1);
    setFwd(5'd5, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("fora_no_write", 32'(ForA), 32'd0);
    setFwd(5'd1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("forb_exmem", 32'(ForB), 32'd2);
    checkVal("fora_nomatch", 32'(ForA), 32'd0);
    setFwd(5'd1, 5'd6, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("forb_memwb", 32'(ForB), 32'd1);

    // Load-to-store forward
    setFwd(5'd0, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    checkVal("forc_on", 32'(ForC), 32'd1);
    setFwd(5'd0, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("forc_no_memtoreg", 32'(ForC), 32'd0);
    setFwd(5'd0, 5'd0, 5'd9, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1);
    checkVal("forc_rd_diff", 32'(ForC), 32'd0);
    setFwd(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkVal("forc_r0", 32'(ForC), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
